// File: rtl/instr_fetch_queue_if.sv
// Bundle of fetch-side, redirect and decode-side signals of instr_fetch_queue.
// The queue uses the slave modport; the environment driving it uses master.
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic [31:0]              fetch_addr;
  logic                     fetch_req;
  logic                     fetch_valid;
  logic [31:0]              fetch_instr;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     deq;
  logic [31:0]              IFQ_Instr;
  logic [31:0]              IFQ_PC;
  logic                     IFQ_empty;
  logic [$clog2(DEPTH):0]   IFQ_count;

  modport slave (
    input  fetch_valid, fetch_instr, redirect, redirect_pc, deq,
    output fetch_addr, fetch_req, IFQ_Instr, IFQ_PC, IFQ_empty, IFQ_count
  );

  modport master (
    output fetch_valid, fetch_instr, redirect, redirect_pc, deq,
    input  fetch_addr, fetch_req, IFQ_Instr, IFQ_PC, IFQ_empty, IFQ_count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner plus circular {PC, instr} queue feeding decode; redirect flushes and restarts.
// Optional macro IFQ_BYPASS_EN forwards fetched data straight to decode while the queue is empty.
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_queue_if.slave bus
);
  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_q, pc_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic q_empty;
  logic fetch_req;
  logic fetch_take;
  logic bypass_hit;
  logic bypass_take;
  logic enq;
  logic deq_fire;

  assign q_empty    = (count_q == '0);
  assign fetch_req  = rst_n && !bus.redirect && (count_q != FULL_CNT);
  assign fetch_take = fetch_req && bus.fetch_valid;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = q_empty && fetch_take;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word consumed by decode in the same cycle never touches storage.
  assign bypass_take = bypass_hit && bus.deq;
  assign enq         = fetch_take && !bypass_take;
  assign deq_fire    = bus.deq && !q_empty && !bus.redirect;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    if (bus.redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (fetch_take) pc_d   = pc_q + 32'd4;
      if (enq)        tail_d = tail_q + PTR_W'(1);
      if (deq_fire)   head_d = head_q + PTR_W'(1);
      if (enq && !deq_fire)      count_d = count_q + CNT_W'(1);
      else if (!enq && deq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]    <= pc_q;
      instr_mem[tail_q] <= bus.fetch_instr;
    end
  end

  assign bus.fetch_addr = pc_q;
  assign bus.fetch_req  = fetch_req;
  assign bus.IFQ_count  = count_q;
  assign bus.IFQ_empty  = q_empty && !bypass_hit;
  assign bus.IFQ_Instr  = !q_empty   ? instr_mem[head_q] :
                          bypass_hit ? bus.fetch_instr   : NOP_INSTR;
  assign bus.IFQ_PC     = !q_empty   ? pc_mem[head_q]    :
                          bypass_hit ? pc_q              : 32'h0;
endmodule
